// File: rtl/frac_clk_gen_multi.sv
// rtl/frac_clk_gen_multi.sv - multi-channel dual-modulus fractional-N clock generator
module frac_clk_gen_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int ACC_W       = 32,
    parameter int RST_DIV_INT = 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_int,
    input  logic [ACC_W-1:0]  cfg_frac,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO, ST_STOP} state_t;

    localparam logic [CH_W:0]  NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [DIV_W:0] CNT_ONE  = {{DIV_W{1'b0}}, 1'b1};

    logic pend_sel;
    logic ch_ok;
    logic cfg_good;
    logic cfg_acc;

    // Out-of-range channels match no pending bit, so they are always ready.
    always_comb begin
        pend_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch == CH_W'(i)) pend_sel = pending[i];
    end

    assign ch_ok     = {1'b0, cfg_ch} < NUM_CH_L;
    assign cfg_good  = ch_ok && (cfg_int != '0);
    assign cfg_ready = !pend_sel;
    assign cfg_acc   = cfg_valid && cfg_ready;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) cfg_err <= 1'b0;
        else       cfg_err <= cfg_acc && !cfg_good;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t             st, st_nxt;
        logic [DIV_W:0]     cnt, cnt_nxt;
        logic [ACC_W-1:0]   acc, acc_nxt, act_frac, sh_frac, base, frac_sel;
        logic [DIV_W-1:0]   act_int, sh_int, int_sel;
        logic [ACC_W:0]     sum;
        logic               out_q, out_nxt, tick_q, tick_nxt, pend_q;
        logic               apply, start, wr;

        assign wr = cfg_acc && cfg_good && (cfg_ch == CH_W'(g));

        always_comb begin
            st_nxt   = st;
            cnt_nxt  = cnt;
            acc_nxt  = acc;
            out_nxt  = out_q;
            tick_nxt = 1'b0;
            apply    = 1'b0;
            start    = 1'b0;
            case (st)
                ST_IDLE: begin
                    acc_nxt = '0;
                    cnt_nxt = '0;
                    apply   = pend_q;
                    if (en[g]) begin
                        st_nxt   = ST_HI;
                        start    = 1'b1;
                        out_nxt  = 1'b1;
                        tick_nxt = 1'b1;
                    end
                end
                ST_HI: begin
                    if (cnt == '0) begin
                        out_nxt = 1'b0;
                        if (en[g]) begin
                            st_nxt = ST_LO;
                            start  = 1'b1;
                        end else begin
                            st_nxt = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                        if (!en[g]) st_nxt = ST_STOP;
                    end
                end
                ST_LO: begin
                    if (!en[g]) begin
                        st_nxt = ST_IDLE;
                    end else if (cnt == '0) begin
                        st_nxt   = ST_HI;
                        start    = 1'b1;
                        out_nxt  = 1'b1;
                        tick_nxt = 1'b1;
                        apply    = pend_q;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        out_nxt = 1'b0;
                        st_nxt  = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
            endcase
            // A freshly applied config or a restart from IDLE begins with a cleared accumulator.
            int_sel  = apply ? sh_int : act_int;
            frac_sel = apply ? sh_frac : act_frac;
            base     = (apply || st == ST_IDLE) ? '0 : acc;
            sum      = {1'b0, base} + {1'b0, frac_sel};
            if (start) begin
                acc_nxt = sum[ACC_W-1:0];
                cnt_nxt = {1'b0, int_sel} + {{DIV_W{1'b0}}, sum[ACC_W]} - CNT_ONE;
            end
        end

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                st       <= ST_IDLE;
                cnt      <= '0;
                acc      <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= 1'b0;
                act_int  <= DIV_W'(RST_DIV_INT);
                act_frac <= '0;
                sh_int   <= DIV_W'(RST_DIV_INT);
                sh_frac  <= '0;
            end else begin
                st     <= st_nxt;
                cnt    <= cnt_nxt;
                acc    <= acc_nxt;
                out_q  <= out_nxt;
                tick_q <= tick_nxt;
                // wr needs pend_q low and apply needs it high, so they never coincide.
                if (apply) begin
                    act_int  <= sh_int;
                    act_frac <= sh_frac;
                    pend_q   <= 1'b0;
                end else if (wr) begin
                    sh_int  <= cfg_int;
                    sh_frac <= cfg_frac;
                    pend_q  <= 1'b1;
                end
            end
        end

        assign clk_out[g] = out_q;
        assign tick[g]    = tick_q;
        assign pending[g] = pend_q;
    end

endmodule

// File: tb/tb_frac_clk_gen_multi.sv
// tb/tb_frac_clk_gen_multi.sv - directed self-checking bench for frac_clk_gen_multi
module tb_frac_clk_gen_multi;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [3:0]  en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_int;
    logic [31:0] cfg_frac;
    logic        cfg_err;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  pending;

    int     n_chk  = 0;
    int     n_fail = 0;
    longint cyc    = 0;

    frac_clk_gen_multi #(.NUM_CH(4), .DIV_W(16), .ACC_W(32), .RST_DIV_INT(1)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_int   (cfg_int),
        .cfg_frac  (cfg_frac),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_put(input logic v, input logic [1:0] ch, input logic [15:0] di, input logic [31:0] df);
        cfg_valid = v;
        cfg_ch    = ch;
        cfg_int   = di;
        cfg_frac  = df;
    endtask

    task automatic wait_tick(input int ch);
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!tick[ch] && n < 100);
        if (!tick[ch]) check("tick_timeout", 64'd0, 64'd1);
    endtask

    // Called at a sample point where clk_out[ch] has just risen; returns at the next rise.
    task automatic measure_hl(input int ch, output int hi, output int lo);
        hi = 0;
        while (clk_out[ch] && hi < 100) begin
            hi++;
            @(negedge clk_in);
        end
        lo = 0;
        while (!clk_out[ch] && lo < 100) begin
            lo++;
            @(negedge clk_in);
        end
        check("rise_tick", 64'(tick[ch]), 64'd1);
    endtask

    initial begin
        int     hi, lo, cnt;
        longint t0;
        reset = 1'b1;
        en    = 4'b0000;
        cfg_put(1'b0, 2'd0, 16'd0, 32'd0);
        repeat (3) @(negedge clk_in);
        check("rst_clk_out", 64'(clk_out), 64'd0);
        check("rst_tick", 64'(tick), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        reset = 1'b0;

        // ch0 {3,0}: 3 high / 3 low
        cfg_put(1'b1, 2'd0, 16'd3, 32'd0);
        #1 check("t1_ready", 64'(cfg_ready), 64'd1);
        @(negedge clk_in);
        cfg_put(1'b0, 2'd0, 16'd0, 32'd0);
        check("t1_pending_set", 64'(pending), 64'b0001);
        @(negedge clk_in);
        check("t1_pending_idle_apply", 64'(pending), 64'b0000);
        en[0] = 1'b1;
        @(negedge clk_in);
        check("t1_first_tick", 64'(tick[0]), 64'd1);
        check("t1_first_high", 64'(clk_out[0]), 64'd1);
        for (int k = 0; k < 2; k++) begin
            measure_hl(0, hi, lo);
            check("t1_hi", 64'(hi), 64'd3);
            check("t1_lo", 64'(lo), 64'd3);
        end

        // ch1 {2, 1/2}: half-periods 2,3 alternate
        cfg_put(1'b1, 2'd1, 16'd2, 32'h8000_0000);
        @(negedge clk_in);
        cfg_put(1'b0, 2'd0, 16'd0, 32'd0);
        @(negedge clk_in);
        check("t2_applied", 64'(pending[1]), 64'd0);
        en[1] = 1'b1;
        @(negedge clk_in);
        check("t2_first_tick", 64'(tick[1]), 64'd1);
        for (int k = 0; k < 2; k++) begin
            measure_hl(1, hi, lo);
            check("t2_hi", 64'(hi), 64'd2);
            check("t2_lo", 64'(lo), 64'd3);
        end

        // ch0 reconfigured to {5,0} during its high phase
        wait_tick(0);
        t0 = cyc;
        cfg_put(1'b1, 2'd0, 16'd5, 32'd0);
        #1 check("t3_ready_ch0", 64'(cfg_ready), 64'd1);
        @(negedge clk_in);
        check("t3_pending_ch0", 64'(pending[0]), 64'd1);
        cfg_put(1'b1, 2'd0, 16'd7, 32'd0);
        #1 check("t3_ready_ch0_blocked", 64'(cfg_ready), 64'd0);
        cfg_put(1'b1, 2'd2, 16'd4, 32'd0);
        #1 check("t3_ready_ch2", 64'(cfg_ready), 64'd1);
        @(negedge clk_in);
        cfg_put(1'b0, 2'd0, 16'd0, 32'd0);
        check("t3_pending_both", 64'(pending), 64'b0101);
        #1 check("t3_ready_ch0_still", 64'(cfg_ready), 64'd0);
        wait_tick(0);
        check("t3_old_period", 64'(cyc - t0), 64'd6);
        check("t3_pending_cleared", 64'(pending), 64'b0000);
        measure_hl(0, hi, lo);
        check("t3_new_hi", 64'(hi), 64'd5);
        check("t3_new_lo", 64'(lo), 64'd5);

        // drop en[0] after the first of 5 high cycles
        en[0] = 1'b0;
        hi = 0;
        @(negedge clk_in);
        while (clk_out[0] && hi < 100) begin
            hi++;
            @(negedge clk_in);
        end
        check("t4_remaining_high", 64'(hi), 64'd4);
        cnt = 0;
        repeat (12) begin
            @(negedge clk_in);
            if (clk_out[0] || tick[0]) cnt++;
        end
        check("t4_idle_quiet", 64'(cnt), 64'd0);

        // invalid write: cfg_int = 0 on running ch1
        cfg_put(1'b1, 2'd1, 16'd0, 32'd0);
        #1 check("t5_ready", 64'(cfg_ready), 64'd1);
        @(negedge clk_in);
        cfg_put(1'b0, 2'd0, 16'd0, 32'd0);
        check("t5_err_pulse", 64'(cfg_err), 64'd1);
        check("t5_pending", 64'(pending), 64'b0000);
        @(negedge clk_in);
        check("t5_err_clear", 64'(cfg_err), 64'd0);
        wait_tick(1);
        measure_hl(1, hi, lo);
        check("t5_hi", 64'(hi), 64'd2);
        check("t5_lo", 64'(lo), 64'd3);

        // reset mid-high with a pending write outstanding
        en = 4'b0111;
        @(negedge clk_in);
        check("t6_start", 64'(tick[0] & tick[2]), 64'd1);
        cfg_put(1'b1, 2'd0, 16'd2, 32'd0);
        @(negedge clk_in);
        cfg_put(1'b0, 2'd0, 16'd0, 32'd0);
        check("t6_pending_before", 64'(pending[0]), 64'd1);
        check("t6_high_before", 64'(clk_out[0] & clk_out[2]), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_clk_out", 64'(clk_out), 64'd0);
        check("t6_rst_pending", 64'(pending), 64'd0);
        check("t6_rst_tick", 64'(tick), 64'd0);
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        check("t6_rel_hi", 64'(clk_out), 64'b0111);
        check("t6_rel_tick", 64'(tick), 64'b0111);
        @(negedge clk_in);
        check("t6_rel_lo", 64'(clk_out), 64'b0000);
        @(negedge clk_in);
        check("t6_rel_hi2", 64'(clk_out), 64'b0111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
